// File: rtl/store_buffer.sv
// store_buffer: in-order write buffer that drains stores to data memory when the port is free.
// Define STORE_BUF_FWD_EN to forward buffered lanes to loads; otherwise any word match stalls the load.
`ifdef STORE_BUF_FWD_EN
// One byte lane of the forwarding merge; inputs are in age order, oldest first.
module store_buffer_lane #(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0]      hit_ord,
  input  logic [DEPTH-1:0][7:0] byte_ord,
  output logic                  covered,
  output logic [7:0]            lane_data
);
  always_comb begin
    covered   = 1'b0;
    lane_data = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      if (hit_ord[i]) begin
        covered   = 1'b1;
        lane_data = byte_ord[i];
      end
    end
  end
endmodule
`endif

module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic              st_byte,
  output logic              st_ready,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic              ld_byte,
  output logic              ld_hit,
  output logic              ld_stall,
  output logic [DATA_W-1:0] ld_data,
  input  logic              mem_busy,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_wd,
  output logic              mem_byte,
  output logic              empty
);
  localparam int LANES = DATA_W / 8;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              is_byte;
  } entry_t;

  entry_t        ent_q [DEPTH];
  entry_t        ent_d [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  // Occupancy is decided by count only; pointers are free to wrap.
  assign empty    = (count_q == '0);
  assign st_ready = (count_q != CW'(DEPTH));
  assign push     = st_valid && st_ready;
  assign mem_we   = !empty && !mem_busy;
  assign pop      = mem_we;
  assign mem_a    = ent_q[head_q].addr;
  assign mem_wd   = ent_q[head_q].data;
  assign mem_byte = ent_q[head_q].is_byte;

  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      ent_d[tail_q].addr    = st_addr;
      ent_d[tail_q].data    = st_byte ? {{(DATA_W-8){1'b0}}, st_data[7:0]} : st_data;
      ent_d[tail_q].is_byte = st_byte;
      tail_d                = tail_q + PW'(1);
    end
    if (pop) head_d = head_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  // Entries re-indexed by age (0 = head); the draining head still participates.
  logic [DEPTH-1:0][PW-1:0] ord_idx;
  logic [DEPTH-1:0]         ord_match;

  always_comb begin
    ord_idx   = '0;
    ord_match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ord_idx[i]   = head_q + PW'(i);
      ord_match[i] = (CW'(i) < count_q) &&
                     (ent_q[ord_idx[i]].addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2]);
    end
  end

`ifdef STORE_BUF_FWD_EN
  logic [LANES-1:0][DEPTH-1:0]      hit_ord;
  logic [LANES-1:0][DEPTH-1:0][7:0] byte_ord;
  logic [LANES-1:0]                 covered;
  logic [LANES-1:0]                 req_lanes;
  logic [LANES-1:0][7:0]            lane_data;

  always_comb begin
    hit_ord  = '0;
    byte_ord = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int i = 0; i < DEPTH; i++) begin
        hit_ord[l][i]  = ord_match[i] &&
                         (!ent_q[ord_idx[i]].is_byte || (ent_q[ord_idx[i]].addr[1:0] == 2'(l)));
        byte_ord[l][i] = ent_q[ord_idx[i]].is_byte ? ent_q[ord_idx[i]].data[7:0]
                                                   : ent_q[ord_idx[i]].data[8*l +: 8];
      end
    end
  end

  assign req_lanes = ld_byte ? (LANES'(1) << ld_addr[1:0]) : '1;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    store_buffer_lane #(.DEPTH(DEPTH)) u_lane (
      .hit_ord   (hit_ord[l]),
      .byte_ord  (byte_ord[l]),
      .covered   (covered[l]),
      .lane_data (lane_data[l])
    );
  end

  assign ld_hit   = ld_valid && ((covered & req_lanes) == req_lanes);
  assign ld_stall = ld_valid && !ld_hit && (|(covered & req_lanes));
  assign ld_data  = ld_hit ? lane_data : '0;
`else
  logic unused_ld;
  assign unused_ld = &{1'b0, ld_byte, ld_addr[1:0]};
  assign ld_hit    = 1'b0;
  assign ld_stall  = ld_valid && (|ord_match);
  assign ld_data   = '0;
`endif

`ifndef SYNTHESIS
  a_one_mem_op: assert property (@(posedge clk) disable iff (rst) !(st_valid && ld_valid));
`endif
endmodule

// File: tb/tb_store_buffer.sv
// Directed vector bench for store_buffer: push/drain ordering, wrap, forwarding and reset mid-drain.
module tb_store_buffer;
`ifdef STORE_BUF_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid, st_byte, st_ready;
  logic [31:0] st_addr, st_data;
  logic        ld_valid, ld_byte, ld_hit, ld_stall;
  logic [31:0] ld_addr, ld_data;
  logic        mem_busy, mem_we, mem_byte, empty;
  logic [31:0] mem_a, mem_wd;

  always #5 clk = ~clk;

  store_buffer dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_byte(st_byte), .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_byte(ld_byte),
    .ld_hit(ld_hit), .ld_stall(ld_stall), .ld_data(ld_data),
    .mem_busy(mem_busy), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_byte(mem_byte),
    .empty(empty)
  );

  typedef struct {
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_byte;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_byte;
    logic        mem_busy;
    logic        e_ready;
    logic        e_empty;
    logic        e_we;
    logic [31:0] e_a;
    logic [31:0] e_wd;
    logic        e_mbyte;
    logic        e_hit;
    logic        e_stall;
    logic [31:0] e_ld_data;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (vec %0d): got %h, expected %h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic sv, input logic [31:0] sa, input logic [31:0] sd, input logic sb,
                              input logic lv, input logic [31:0] la, input logic lb, input logic busy,
                              input logic rdy, input logic emp, input logic we, input logic [31:0] a,
                              input logic [31:0] wd, input logic mb, input logic hit, input logic stall,
                              input logic [31:0] ldd);
    vec_t v;
    v.st_valid = sv;  v.st_addr = sa;  v.st_data = sd;  v.st_byte = sb;
    v.ld_valid = lv;  v.ld_addr = la;  v.ld_byte = lb;  v.mem_busy = busy;
    v.e_ready = rdy;  v.e_empty = emp; v.e_we = we;     v.e_a = a;
    v.e_wd = wd;      v.e_mbyte = mb;  v.e_hit = hit;   v.e_stall = stall;
    v.e_ld_data = ldd;
    return v;
  endfunction

  task automatic add_st(input logic [31:0] a, input logic [31:0] d, input logic b, input logic busy,
                        input logic rdy, input logic emp);
    vq.push_back(mk(1'b1, a, d, b, 1'b0, '0, 1'b0, busy, rdy, emp, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0));
  endtask

  task automatic add_idle(input logic busy, input logic rdy, input logic emp, input logic we,
                          input logic [31:0] a, input logic [31:0] wd, input logic mb);
    vq.push_back(mk(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, busy, rdy, emp, we, a, wd, mb, 1'b0, 1'b0, '0));
  endtask

  // Loads keep mem_busy high, so no drain happens on those cycles.
  task automatic add_ld(input logic [31:0] a, input logic b, input logic rdy, input logic emp,
                        input logic hit, input logic stall, input logic [31:0] d);
    vq.push_back(mk(1'b0, '0, '0, 1'b0, 1'b1, a, b, 1'b1, rdy, emp, 1'b0, '0, '0, 1'b0, hit, stall, d));
  endtask

  task automatic check_reset_vals(input int idx);
    chk("rst_st_ready", idx, st_ready, 1'b1);
    chk("rst_empty",    idx, empty,    1'b1);
    chk("rst_mem_we",   idx, mem_we,   1'b0);
    chk("rst_ld_hit",   idx, ld_hit,   1'b0);
    chk("rst_ld_stall", idx, ld_stall, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    st_valid = 1'b0; st_addr = '0; st_data = '0; st_byte = 1'b0;
    ld_valid = 1'b0; ld_addr = '0; ld_byte = 1'b0; mem_busy = 1'b0;

    // Idle after reset
    repeat (5) add_idle(1'b0, 1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
    // Single word store, one-cycle latency to memory
    add_st(32'h100, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b1);
    add_idle(1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 1'b0);
    add_idle(1'b0, 1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
    // Fill while memory busy, rejected pushes, then in-order drain across the pointer wrap
    add_st(32'h10, 32'h11111111, 1'b0, 1'b1, 1'b1, 1'b1);
    add_st(32'h21, 32'h00000022, 1'b1, 1'b1, 1'b1, 1'b0);
    add_st(32'h30, 32'h33333333, 1'b0, 1'b1, 1'b1, 1'b0);
    add_st(32'h43, 32'h00000044, 1'b1, 1'b1, 1'b1, 1'b0);
    add_st(32'h50, 32'h55555555, 1'b0, 1'b1, 1'b0, 1'b0);
    add_st(32'h50, 32'h55555555, 1'b0, 1'b1, 1'b0, 1'b0);
    add_idle(1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 32'h11111111, 1'b0);
    add_idle(1'b0, 1'b1, 1'b0, 1'b1, 32'h21, 32'h00000022, 1'b1);
    add_idle(1'b0, 1'b1, 1'b0, 1'b1, 32'h30, 32'h33333333, 1'b0);
    add_idle(1'b0, 1'b1, 1'b0, 1'b1, 32'h43, 32'h00000044, 1'b1);
    add_idle(1'b0, 1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
    // Byte over word merge
    add_st(32'h200, 32'h11223344, 1'b0, 1'b1, 1'b1, 1'b1);
    add_st(32'h202, 32'h000000AA, 1'b1, 1'b1, 1'b1, 1'b0);
    add_ld(32'h200, 1'b0, 1'b1, 1'b0, FWD, !FWD, 32'h11AA3344);
    add_ld(32'h204, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    add_idle(1'b0, 1'b1, 1'b0, 1'b1, 32'h200, 32'h11223344, 1'b0);
    add_idle(1'b0, 1'b1, 1'b0, 1'b1, 32'h202, 32'h000000AA, 1'b1);
    add_idle(1'b0, 1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
    // Partial overlap stalls until drained; byte hit and disjoint byte
    add_st(32'h301, 32'h00000055, 1'b1, 1'b1, 1'b1, 1'b1);
    add_ld(32'h300, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0);
    add_ld(32'h300, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0);
    add_ld(32'h301, 1'b1, 1'b1, 1'b0, FWD, !FWD, 32'h00005500);
    add_ld(32'h303, 1'b1, 1'b1, 1'b0, 1'b0, !FWD, '0);
    add_idle(1'b0, 1'b1, 1'b0, 1'b1, 32'h301, 32'h00000055, 1'b1);
    add_ld(32'h300, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    // Youngest word to the same address wins
    add_st(32'h400, 32'hAAAAAAAA, 1'b0, 1'b1, 1'b1, 1'b1);
    add_st(32'h400, 32'hBBBBBBBB, 1'b0, 1'b1, 1'b1, 1'b0);
    add_ld(32'h400, 1'b0, 1'b1, 1'b0, FWD, !FWD, 32'hBBBBBBBB);
    add_idle(1'b0, 1'b1, 1'b0, 1'b1, 32'h400, 32'hAAAAAAAA, 1'b0);
    add_idle(1'b0, 1'b1, 1'b0, 1'b1, 32'h400, 32'hBBBBBBBB, 1'b0);
    add_idle(1'b0, 1'b1, 1'b1, 1'b0, '0, '0, 1'b0);

    #1;
    check_reset_vals(-1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      st_valid = vq[i].st_valid; st_addr = vq[i].st_addr; st_data = vq[i].st_data; st_byte = vq[i].st_byte;
      ld_valid = vq[i].ld_valid; ld_addr = vq[i].ld_addr; ld_byte = vq[i].ld_byte; mem_busy = vq[i].mem_busy;
      #1;
      chk("st_ready", i, st_ready, vq[i].e_ready);
      chk("empty",    i, empty,    vq[i].e_empty);
      chk("mem_we",   i, mem_we,   vq[i].e_we);
      chk("ld_hit",   i, ld_hit,   vq[i].e_hit);
      chk("ld_stall", i, ld_stall, vq[i].e_stall);
      if (vq[i].e_we) begin
        chk("mem_a",    i, mem_a,    vq[i].e_a);
        chk("mem_wd",   i, mem_wd,   vq[i].e_wd);
        chk("mem_byte", i, mem_byte, vq[i].e_mbyte);
      end
      if (vq[i].e_hit || !vq[i].ld_valid) chk("ld_data", i, ld_data, vq[i].e_ld_data);
    end

    // Reset while three entries are held and the head is being written
    @(negedge clk);
    st_valid = 1'b0; ld_valid = 1'b0; mem_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      st_valid = 1'b1; st_byte = 1'b0; st_addr = 32'h500 + 32'(4 * k); st_data = 32'hC0DE0000 + 32'(k);
    end
    @(negedge clk);
    st_valid = 1'b0; mem_busy = 1'b0;
    #1;
    chk("pre_rst_mem_we", 1000, mem_we, 1'b1);
    chk("pre_rst_mem_a",  1000, mem_a,  32'h500);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals(1001);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk("post_rst_mem_we", 1002 + k, mem_we, 1'b0);
      chk("post_rst_empty",  1002 + k, empty,  1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Small in-order write buffer between the memory-stage control and the data memory wrapper.
- Accepts retiring stores, which are either a full word or a single byte.
- Drains one store per cycle to the data memory whenever the memory port is not used by a load.
- Forwards buffered data to loads, so stores cost no pipeline stall unless the buffer is full or a load partially overlaps buffered bytes.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; fixed at 4 byte lanes.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous active-high reset.
- st_valid  in  1  store request this cycle.
- st_addr  in  ADDR_W  store byte address.
- st_data  in  DATA_W  store data; for byte stores only bits [7:0] are used.
- st_byte  in  1  1 = byte store, 0 = word store.
- st_ready  out  1  buffer can accept a store this cycle.
- ld_valid  in  1  load lookup this cycle.
- ld_addr  in  ADDR_W  load byte address.
- ld_byte  in  1  1 = byte load, 0 = word load.
- ld_hit  out  1  all requested bytes come from the buffer.
- ld_stall  out  1  partial overlap; the load must wait.
- ld_data  out  DATA_W  forwarded word, lane-aligned to ld_addr[31:2].
- mem_busy  in  1  memory port is used by a load this cycle.
- mem_we  out  1  write enable to the data memory.
- mem_a  out  ADDR_W  write address.
- mem_wd  out  DATA_W  write data; byte in [7:0] for byte stores.
- mem_byte  out  1  byte-select to the data memory: 1 = Byte, 0 = Word.
- empty  out  1  no entries held; used for fence and debug halt.

Behaviour:
- Storage and reset:
  - Circular FIFO with head pointer, tail pointer and count register.
  - Each entry holds addr, data and byte flag.
  - Reset clears head, tail and count; entry contents are don't-care.
  - Reset values: st_ready=1, empty=1, mem_we=0, ld_hit=0, ld_stall=0.
  - Reset mid-drain discards all entries; no write is issued after reset asserts.
- Push:
  - st_ready = (count != DEPTH), from registered count only.
  - A pop in the same cycle does not free a slot for a push. When full, st_ready stays 0 for that cycle.
  - Store accepted when st_valid && st_ready; it is written at the tail on the next edge.
  - st_valid && !st_ready: no state change; the requester holds its inputs.
- Drain:
  - mem_we = !empty && !mem_busy, combinational.
  - mem_a, mem_wd and mem_byte come from the head entry.
  - The head pops on the edge where mem_we=1.
  - Latency: a store pushed into an empty buffer reaches the memory one cycle after acceptance, at the earliest.
- Simultaneous push and pop: count is unchanged; both pointers advance.
- Pointer wrap: pointers wrap modulo DEPTH; full/empty are decided by count, never by pointer compare.
- Load lookup (combinational, qualified by ld_valid):
  - Required lanes: word load = 4'b1111; byte load = one-hot of ld_addr[1:0].
  - An entry matches when entry.addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2].
  - Lanes contributed: a word store covers all 4 lanes; a byte store covers lane addr[1:0].
  - For each lane, data comes from the youngest valid matching entry covering that lane.
  - The head entry draining this cycle still counts.
  - The store accepted in the same cycle is not visible.
  - Covered ⊇ required: ld_hit=1, ld_stall=0, ld_data = merged lanes. Non-covered lanes of ld_data are 0.
  - Covered ∩ required empty: ld_hit=0, ld_stall=0; the load reads memory.
  - Otherwise: ld_hit=0, ld_stall=1.
  - ld_valid=0: ld_hit=0, ld_stall=0, ld_data=0.
- st_valid and ld_valid are mutually exclusive (single memory op per cycle). A simulation-only assertion flags a violation.
- Sign/zero extension of load results stays in the data memory wrapper and its consumer, not here.

Optional Feature:
- STORE_BUF_FWD_EN defined: lane forwarding exactly as described under Behaviour.
- Undefined: no data path for forwarding; ld_hit is tied to 0 and ld_data to 0.
- Undefined: any word-address match with any valid entry asserts ld_stall=1, regardless of lanes.
- Undefined: push, drain and reset behaviour are identical to the defined case.

Test Plan:
- Reset then idle -> empty=1, st_ready=1, mem_we=0 for 5 cycles.
- Word store 0xDEADBEEF @0x100 with mem_busy=0 -> next cycle mem_we=1, mem_a=0x100, mem_wd=0xDEADBEEF, mem_byte=0; following cycle empty=1.
- mem_busy=1, push 4 stores -> st_ready=0 after the 4th; push attempts are ignored. Release mem_busy -> 4 writes in FIFO order on consecutive cycles, pointers wrap correctly.
- Buffer word 0x11223344 @0x200, then byte 0xAA @0x202; word load @0x200 -> ld_hit=1, ld_data=0x11AA3344.
- Buffer byte 0x55 @0x301; word load @0x300 -> ld_stall=1 with forwarding, until drained. Byte load @0x301 -> ld_hit=1, ld_data=0x00005500. Byte load @0x303 -> hit=0, stall=0.
- Assert rst while 3 entries are held and mem_we=1 -> outputs return to reset values immediately; no further writes after release.
